aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
Iterative AES-128 encryption controller. It sequences one shared external round datapath (regular round and final round) through the 10 AES rounds. It performs the initial AddRoundKey and generates round keys on the fly. It sits between a valid/ready block source and the ciphertext consumer, one block in flight at a time.

Parameters:
ROUND_LAT, 3, cycles from rnd_start until rnd_dout is valid for the issued round (legal range 1..15)
NR, 10, number of AES rounds (fixed for AES-128; not overridable in practice)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  plaintext and key present
in_ready  output  1  sequencer can accept a block
in_pt  input  128  plaintext; bit 127 is byte 0 (FIPS-197 order)
in_key  input  128  cipher key, same byte order
out_valid  output  1  ciphertext present
out_ready  input  1  consumer accepts ciphertext
out_ct  output  128  ciphertext
rnd_start  output  1  one-cycle pulse: datapath operands valid
rnd_final  output  1  1 selects the final-round datapath (no MixColumns)
rnd_din  output  128  round input state
rnd_key  output  128  round key for this round
rnd_dout  input  128  datapath result, sampled ROUND_LAT cycles after the end of the issue cycle
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at clk edge): state IDLE. in_ready=1, out_valid=0, out_ct=0, rnd_start=0, rnd_final=0, rnd_din=0, rnd_key=0, busy=0. Internal round counter=0, latency counter=0, round-key and state registers=0.
- Reset mid-operation abandons the block. No partial output is ever produced.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, load state_reg=in_pt^in_key, rk_reg=in_key, rnd=1, then go to ISSUE.
- ISSUE (1 cycle):
  - Compute nk = key_step(rk_reg, rcon[rnd]).
  - Register rnd_din=state_reg, rnd_key=nk, rnd_final=(rnd==NR), rnd_start=1 for exactly this cycle.
  - Set rk_reg=nk and lat_cnt=ROUND_LAT, then go to WAIT.
- WAIT:
  - rnd_din, rnd_key and rnd_final are held stable; rnd_start=0.
  - lat_cnt decrements each cycle. In the cycle where lat_cnt==1, capture state_reg=rnd_dout.
  - After the capture: if rnd==NR, load out_ct=rnd_dout and go to DONE. Otherwise rnd=rnd+1 and go to ISSUE.
- DONE: out_valid=1 and out_ct held stable until out_ready. On out_valid&out_ready, go to IDLE; in_ready rises the next cycle. out_ct keeps its value until the next block's DONE load.
- Latency: handshake accept at cycle 0 gives out_valid at cycle 1+NR*(1+ROUND_LAT). This is 41 for the default ROUND_LAT=3.
- Throughput: one block per (latency + 1 + output stall) cycles.
- in_ready=0 in ISSUE/WAIT/DONE. in_valid is ignored there, and in_pt/in_key need not be held.
- out_ready=1 while not in DONE has no effect. out_ready already high on DONE entry gives a single-cycle out_valid.
- rcon sequence for rnd 1..10: 01,02,04,08,10,20,40,80,1b,36.

Optional Feature:
AES_SEQ_ABORT_EN: adds input port abort (1 bit).
- With the macro: abort==1 in ISSUE, WAIT or DONE forces IDLE on the next edge and clears out_valid and rnd_start. abort in IDLE is ignored. abort has priority over out_ready in DONE. Outputs of the aborted block are never presented.
- Without the macro: no abort port; the FSM always completes the block.

Decomposition:
- Shared package aes_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE}
  - constant NR=10
  - rcon lookup function
  - 128-bit block typedef
  - S-box function, shared with sub_bytes
- One sub-module, aes_key_step: combinational next-round-key generator. Inputs are a 128-bit key and an 8-bit rcon; it applies RotWord, SubWord and the XOR chain. It is instantiated once in the sequencer.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_ct 3925841d02dc09fbdc118597196a0b32, out_valid at cycle 41 after accept; the bench models the round datapath with ROUND_LAT=3.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_ct 69c4e0d86a7b0430d8cdb78070b4c55a. Exactly 10 rnd_start pulses; rnd_final=1 only on the 10th. rnd_key on round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
- Output backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_ct stable, in_ready=0 throughout. out_ready=1 -> in_ready=1 the next cycle. A back-to-back second block starts correctly.
- Reset mid-operation: reset=0 during WAIT of round 5 -> next cycle all outputs at reset values. A subsequent App. B block gives the correct ciphertext.
- ROUND_LAT=1 build: App. C.1 vector -> same ciphertext with out_valid at cycle 21. in_valid asserted during busy is ignored.
- AES_SEQ_ABORT_EN build: abort in WAIT of round 7 -> IDLE next cycle, out_valid never asserted. abort in DONE with out_ready=1 -> no transfer.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and the forward S-box used by the
// key schedule and by any SubBytes implementation.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int NR = 10;

  // Byte x of the table sits at bits [8*(255-x) +: 8], i.e. row 0 is the top word.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational AES-128 key expansion step: one round key to the next
// (RotWord, SubWord, rcon, then the word XOR chain).
module aes_key_step (
  input  logic [127:0] key,
  input  logic [7:0]   rcon_byte,
  output logic [127:0] next_key
);
  import aes_pkg::*;

  logic [31:0] w0_s, w1_s, w2_s, w3_s;
  logic [31:0] t_s;
  logic [31:0] n0_s, n1_s, n2_s, n3_s;

  assign {w0_s, w1_s, w2_s, w3_s} = key;

  // RotWord moves the leading byte of w3 to the end before substitution.
  assign t_s = {sbox(w3_s[23:16]), sbox(w3_s[15:8]), sbox(w3_s[7:0]), sbox(w3_s[31:24])}
             ^ {rcon_byte, 24'h000000};

  assign n0_s = w0_s ^ t_s;
  assign n1_s = w1_s ^ n0_s;
  assign n2_s = w2_s ^ n1_s;
  assign n3_s = w3_s ^ n2_s;

  assign next_key = {n0_s, n1_s, n2_s, n3_s};
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller sequencing an external round datapath through NR rounds.
// Optional build macro AES_SEQ_ABORT_EN adds an abort input.
module aes_round_sequencer #(
  parameter int ROUND_LAT = 3,
  parameter int NR        = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic         rnd_start,
  output logic         rnd_final,
  output logic [127:0] rnd_din,
  output logic [127:0] rnd_key,
  input  logic [127:0] rnd_dout,
  output logic         busy
`ifdef AES_SEQ_ABORT_EN
  ,
  input  logic         abort
`endif
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_RND = 4'(NR);
  localparam logic [3:0] LAT_INIT = 4'(ROUND_LAT);

  seq_state_t state_r;
  block_t     state_blk_r;
  block_t     rk_r;
  block_t     nk_s;
  logic [3:0] rnd_r;
  logic [3:0] lat_cnt_r;
  logic [7:0] rcon_s;
  logic       abort_s;

`ifdef AES_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign rcon_s = rcon(rnd_r);

  aes_key_step u_key_step (
    .key       (rk_r),
    .rcon_byte (rcon_s),
    .next_key  (nk_s)
  );

  // Sequencer FSM with all handshake and datapath-facing outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_ct      <= 128'h0;
      rnd_start   <= 1'b0;
      rnd_final   <= 1'b0;
      rnd_din     <= 128'h0;
      rnd_key     <= 128'h0;
      busy        <= 1'b0;
      rnd_r       <= 4'd0;
      lat_cnt_r   <= 4'd0;
      rk_r        <= 128'h0;
      state_blk_r <= 128'h0;
    end else begin
      rnd_start <= 1'b0;
      if (abort_s && (state_r != IDLE)) begin
        state_r   <= IDLE;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (in_valid) begin
              state_blk_r <= in_pt ^ in_key;
              rk_r        <= in_key;
              rnd_r       <= 4'd1;
              in_ready    <= 1'b0;
              busy        <= 1'b1;
              state_r     <= ISSUE;
            end
          end
          ISSUE: begin
            rnd_din   <= state_blk_r;
            rnd_key   <= nk_s;
            rnd_final <= (rnd_r == LAST_RND);
            rnd_start <= 1'b1;
            rk_r      <= nk_s;
            lat_cnt_r <= LAT_INIT;
            state_r   <= WAIT;
          end
          WAIT: begin
            lat_cnt_r <= lat_cnt_r - 4'd1;
            // The datapath result is only guaranteed in the last latency cycle.
            if (lat_cnt_r == 4'd1) begin
              state_blk_r <= rnd_dout;
              if (rnd_r == LAST_RND) begin
                out_ct    <= rnd_dout;
                out_valid <= 1'b1;
                state_r   <= DONE;
              end else begin
                rnd_r   <= rnd_r + 4'd1;
                state_r <= ISSUE;
              end
            end
          end
          DONE: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state_r   <= IDLE;
            end
          end
          default: begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a behavioural AES round datapath.
// Define AES_SEQ_ABORT_EN to also exercise the abort input.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam int ROUND_LAT = 3;
  localparam int LATENCY   = 1 + 10 * (1 + ROUND_LAT);

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_pt = 128'h0;
  logic [127:0] in_key = 128'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_ct;
  logic         rnd_start;
  logic         rnd_final;
  logic [127:0] rnd_din;
  logic [127:0] rnd_key;
  logic [127:0] rnd_dout = 128'h0;
  logic         busy;
`ifdef AES_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;

  int           start_cnt = 0;
  int           final_cnt = 0;
  int           last_final_at = 0;
  logic [127:0] key_log [256];

  int           dp_cnt = -1;
  logic [127:0] dp_res = 128'h0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.ROUND_LAT(ROUND_LAT)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .rnd_start (rnd_start),
    .rnd_final (rnd_final),
    .rnd_din   (rnd_din),
    .rnd_key   (rnd_key),
    .rnd_dout  (rnd_dout),
    .busy      (busy)
`ifdef AES_SEQ_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] din, input logic [127:0] key,
                                             input logic fin);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = sbox(din[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res ^ key;
  endfunction

  // Round datapath: result is correct only in the single cycle the sequencer should sample it.
  always @(negedge clk) begin
    if (rnd_start) begin
      dp_res = aes_round(rnd_din, rnd_key, rnd_final);
      dp_cnt = ROUND_LAT - 1;
    end else if (dp_cnt >= 0) begin
      dp_cnt--;
    end
    rnd_dout = (dp_cnt == 0) ? dp_res : ~dp_res;
  end

  // Issue monitor, sampling the values of the cycle that just ended.
  always @(posedge clk) begin
    if (rnd_start) begin
      key_log[start_cnt % 256] = rnd_key;
      start_cnt++;
      if (rnd_final) begin
        final_cnt++;
        last_final_at = start_cnt;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    in_pt = pt;
    in_key = key;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_pt = ~pt;
    in_key = ~key;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_starts(input int base, input int n);
    int k = 0;
    while ((start_cnt - base) < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("start_reach", 128'(start_cnt - base), 128'(n));
  endtask

  initial begin
    int           lat;
    int           s0;
    int           f0;
    logic [127:0] held;
    logic         stable;
    logic         seen;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ct", out_ct, 128'h0);
    check("rst_rnd", {rnd_start, rnd_final, busy}, 3'b000);
    check("rst_din_key", rnd_din | rnd_key, 128'h0);
    reset = 1'b1;
    @(negedge clk);

    // FIPS-197 App. B, with junk on in_valid while busy.
    send(B_PT, B_KEY);
    in_valid = 1'b1;
    in_pt = C_PT;
    in_key = C_KEY;
    repeat (5) @(negedge clk);
    check("busy_in_ready", {in_ready, busy}, 2'b01);
    in_valid = 1'b0;
    wait_valid(lat);
    lat += 5;
    check("b_latency", 128'(lat), 128'(LATENCY));
    check("b_ct", out_ct, B_CT);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b_idle", {in_ready, out_valid, busy}, 3'b100);

    // App. C.1 with issue monitoring and output backpressure.
    s0 = start_cnt;
    f0 = final_cnt;
    send(C_PT, C_KEY);
    wait_valid(lat);
    check("c_latency", 128'(lat), 128'(LATENCY));
    check("c_ct", out_ct, C_CT);
    check("c_starts", 128'(start_cnt - s0), 128'd10);
    check("c_finals", 128'(final_cnt - f0), 128'd1);
    check("c_final_on_10", 128'(last_final_at - s0), 128'd10);
    check("c_rk1", key_log[s0 % 256], C_RK1);
    held = out_ct;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_ct !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", stable, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {in_ready, out_valid}, 2'b10);

    // Back-to-back block with out_ready already high: single-cycle out_valid.
    send(B_PT, B_KEY);
    wait_valid(lat);
    check("b2b_latency", 128'(lat), 128'(LATENCY));
    check("b2b_ct", out_ct, B_CT);
    @(negedge clk);
    check("b2b_single", {out_valid, in_ready}, 2'b01);
    check("b2b_ct_hold", out_ct, B_CT);
    out_ready = 1'b0;

    // Reset during WAIT of round 5.
    s0 = start_cnt;
    send(C_PT, C_KEY);
    wait_starts(s0, 5);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_ctl", {in_ready, out_valid, rnd_start, rnd_final, busy}, 5'b10000);
    check("mid_rst_ct", out_ct, 128'h0);
    check("mid_rst_din_key", rnd_din | rnd_key, 128'h0);
    repeat (3) @(negedge clk);
    send(B_PT, B_KEY);
    wait_valid(lat);
    check("post_rst_ct", out_ct, B_CT);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

`ifdef AES_SEQ_ABORT_EN
    // Abort during WAIT of round 7: nothing is ever presented.
    s0 = start_cnt;
    send(B_PT, B_KEY);
    wait_starts(s0, 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_wait", {in_ready, busy, out_valid}, 3'b100);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("abort_quiet", seen, 1'b0);
    send(C_PT, C_KEY);
    wait_valid(lat);
    check("abort_pre_done", out_ct, C_CT);
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    check("abort_done", {in_ready, out_valid, busy}, 3'b100);
    send(B_PT, B_KEY);
    wait_valid(lat);
    check("post_abort_ct", out_ct, B_CT);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
`else
    seen = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
